spi_slave_gen: RTL and testbench

Parametrised next-generation SPI slave: N-bit words, selectable CPOL/CPHA mode and bit order, continuous multi-word transfers under one chip-select. Runs entirely in the system clock domain: oversamples the external SCLK/CS/MOSI pins and provides a buffered TX valid/ready interface and an RX valid/ready interface to core logic. Sits between the pad ring and register/FIFO logic, alongside the SPI master.

---
 rtl/spi_slave_gen.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI slave oversampled in the clk_c domain, with a one-word TX buffer and a held RX word.
// Define SPI_SLAVE_ERR_EN to build the sticky overrun/underrun flags; otherwise both read 0.
module spi_slave_gen #(
    parameter int N         = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk_c,
    input  logic         reset_r,
    input  logic         sclk_i,
    input  logic         cs_n_i,
    input  logic         mosi_i,
    output logic         miso_o,
    output logic         miso_oe_o,
    input  logic [N-1:0] tx_data_i,
    input  logic         tx_valid_i,
    output logic         tx_ready_o,
    output logic [N-1:0] rx_data_o,
    output logic         rx_valid_o,
    input  logic         rx_ready_i,
    output logic         busy_o,
    output logic         overrun_o,
    output logic         underrun_o,
    input  logic         err_clr_i
);

    localparam int CW = $clog2(N);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic          sclk_s1, sclk_s2, sclk_s3;
    logic          cs_s1, cs_s2, cs_s3;
    logic          mosi_s1, mosi_s2;
    logic          sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic          sample_edge, shift_edge, cs_fall;
    logic [0:0]    state;
    logic [CW-1:0] bit_cnt;
    logic          word_pend;
    logic [N-1:0]  tx_sh, rx_sh, tx_buf, start_word;
    logic          tx_full, rx_done, miso_r;
    logic          do_start, consume, ur_set, ov_set, accept;

    function automatic logic head(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    function automatic logic [N-1:0] shift_out(input logic [N-1:0] w);
        return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] w, input logic b);
        return MSB_FIRST ? {w[N-2:0], b} : {b, w[N-1:1]};
    endfunction

    // CS sync flops reset to "selected" so a CS already low at reset release is not seen as a new falling edge.
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_s3 <= CPOL;
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_s3   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk_i;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= cs_n_i;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= mosi_i;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise   = sclk_s2 & ~sclk_s3;
    assign sclk_fall   = ~sclk_s2 & sclk_s3;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_s3 & ~cs_s2;

    assign start_word = tx_full ? tx_buf : '0;
    assign do_start   = ((state == IDLE) && cs_fall) ||
                        ((state == ACTIVE) && !cs_s2 && shift_edge && word_pend);
    assign consume    = do_start && tx_full;
    assign ur_set     = do_start && !tx_full;

    // A completed word arms word_pend; the following shift edge loads the next TX word.
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            word_pend <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_done   <= 1'b0;
            miso_r    <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        bit_cnt   <= '0;
                        word_pend <= 1'b0;
                        tx_sh     <= start_word;
                        if (!CPHA) miso_r <= head(start_word);
                    end
                end
                default: begin
                    if (cs_s2) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        word_pend <= 1'b0;
                        miso_r    <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_sh <= shift_in(rx_sh, mosi_s2);
                            if (bit_cnt == CW'(N - 1)) begin
                                bit_cnt   <= '0;
                                rx_done   <= 1'b1;
                                word_pend <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (word_pend) begin
                                word_pend <= 1'b0;
                                miso_r    <= head(start_word);
                                tx_sh     <= CPHA ? shift_out(start_word) : start_word;
                            end else if (CPHA) begin
                                miso_r <= head(tx_sh);
                                tx_sh  <= shift_out(tx_sh);
                            end else begin
                                miso_r <= head(shift_out(tx_sh));
                                tx_sh  <= shift_out(tx_sh);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (tx_valid_i && !tx_full) begin
            tx_buf  <= tx_data_i;
            tx_full <= 1'b1;
        end else if (consume) begin
            tx_full <= 1'b0;
        end
    end

    assign accept = rx_valid_o && rx_ready_i;
    assign ov_set = rx_done && rx_valid_o && !rx_ready_i;

    // A word finishing while the previous one is still unaccepted is dropped.
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else if (rx_done && (!rx_valid_o || accept)) begin
            rx_data_o  <= rx_sh;
            rx_valid_o <= 1'b1;
        end else if (accept) begin
            rx_valid_o <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    logic overrun_r, underrun_r;

    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (ov_set) overrun_r <= 1'b1;
            else if (err_clr_i) overrun_r <= 1'b0;
            if (ur_set) underrun_r <= 1'b1;
            else if (err_clr_i) underrun_r <= 1'b0;
        end
    end

    assign overrun_o  = overrun_r;
    assign underrun_o = underrun_r;
`else
    logic unused_err;
    assign unused_err = ^{err_clr_i, ov_set, ur_set};
    assign overrun_o  = 1'b0;
    assign underrun_o = 1'b0;
`endif

    assign miso_o     = miso_r;
    assign miso_oe_o  = (state == ACTIVE);
    assign busy_o     = (state == ACTIVE);
    assign tx_ready_o = ~tx_full;

endmodule

// File: tb/tb_spi_slave_gen.sv
// tb_spi_slave_gen: drives three spi_slave_gen instances (mode 0 MSB, mode 3 MSB, mode 1 LSB) from a bit-level SPI master.
// Received words and MISO words are checked against scoreboard queues filled as stimulus is issued.
module tb_spi_slave_gen;

`ifdef SPI_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk[3], cs_n[3], mosi[3], miso[3], miso_oe[3];
    logic       tx_valid[3], tx_ready[3], rx_valid[3], rx_ready[3];
    logic       busy[3], overrun[3], underrun[3], err_clr[3];
    logic [7:0] tx_data[3], rx_data[3];

    int         total = 0;
    int         bad = 0;
    logic [7:0] rxExp[$];
    logic [7:0] misoExp[$];
    logic [7:0] mi;

    always #5 clk = ~clk;

    spi_slave_gen #(.N(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_m0 (
        .clk_c(clk), .reset_r(reset), .sclk_i(sclk[0]), .cs_n_i(cs_n[0]), .mosi_i(mosi[0]),
        .miso_o(miso[0]), .miso_oe_o(miso_oe[0]), .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
        .tx_ready_o(tx_ready[0]), .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]),
        .rx_ready_i(rx_ready[0]), .busy_o(busy[0]), .overrun_o(overrun[0]),
        .underrun_o(underrun[0]), .err_clr_i(err_clr[0])
    );

    spi_slave_gen #(.N(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) dut_m3 (
        .clk_c(clk), .reset_r(reset), .sclk_i(sclk[1]), .cs_n_i(cs_n[1]), .mosi_i(mosi[1]),
        .miso_o(miso[1]), .miso_oe_o(miso_oe[1]), .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
        .tx_ready_o(tx_ready[1]), .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]),
        .rx_ready_i(rx_ready[1]), .busy_o(busy[1]), .overrun_o(overrun[1]),
        .underrun_o(underrun[1]), .err_clr_i(err_clr[1])
    );

    spi_slave_gen #(.N(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_m1l (
        .clk_c(clk), .reset_r(reset), .sclk_i(sclk[2]), .cs_n_i(cs_n[2]), .mosi_i(mosi[2]),
        .miso_o(miso[2]), .miso_oe_o(miso_oe[2]), .tx_data_i(tx_data[2]), .tx_valid_i(tx_valid[2]),
        .tx_ready_o(tx_ready[2]), .rx_data_o(rx_data[2]), .rx_valid_o(rx_valid[2]),
        .rx_ready_i(rx_ready[2]), .busy_o(busy[2]), .overrun_o(overrun[2]),
        .underrun_o(underrun[2]), .err_clr_i(err_clr[2])
    );

    function automatic bit cpolOf(input int i);
        return (i == 1);
    endfunction

    function automatic bit cphaOf(input int i);
        return (i != 0);
    endfunction

    function automatic bit msbOf(input int i);
        return (i != 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csAssert(input int i);
        @(negedge clk);
        cs_n[i] = 1'b0;
        waitClk(8);
    endtask

    task automatic csRelease(input int i);
        waitClk(4);
        cs_n[i] = 1'b1;
        waitClk(8);
    endtask

    task automatic errClr(input int i);
        @(negedge clk);
        err_clr[i] = 1'b1;
        @(negedge clk);
        err_clr[i] = 1'b0;
    endtask

    // Offer a word on the TX handshake; tracked words are expected back on MISO in order.
    task automatic txPush(input int i, input logic [7:0] d, input bit track);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (tx_ready[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid[i] = 1'b0;
        if (!ok) checkOutput("tx_ready_wait", {31'b0, tx_ready[i]}, 32'd1);
        if (track) misoExp.push_back(d);
    endtask

    // Bit-level master: shifts mo out on MOSI for nbits and collects MISO at each sample edge.
    task automatic applyStimulus(input int i, input logic [7:0] mo, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            int idx;
            idx = msbOf(i) ? 7 - b : b;
            if (!cphaOf(i)) begin
                mosi[i] = mo[idx];
                waitClk(4);
                sclk[i] = ~cpolOf(i);
                got[idx] = miso[i];
                waitClk(4);
                sclk[i] = cpolOf(i);
            end else begin
                sclk[i] = ~cpolOf(i);
                mosi[i] = mo[idx];
                waitClk(4);
                sclk[i] = cpolOf(i);
                got[idx] = miso[i];
                waitClk(4);
            end
        end
    endtask

    task automatic checkMiso(input logic [7:0] got);
        if (misoExp.size() == 0) checkOutput("miso_extra", 32'(misoExp.size()), 32'd1);
        else checkOutput("miso_word", got, misoExp.pop_front());
    endtask

    // Pop an expected RX word on every accepted handshake of any instance.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rx_valid[i] && rx_ready[i]) begin
                if (rxExp.size() == 0) checkOutput("rx_extra", 32'(rxExp.size()), 32'd1);
                else checkOutput("rx_word", rx_data[i], rxExp.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk[i]     = cpolOf(i);
            cs_n[i]     = 1'b1;
            mosi[i]     = 1'b0;
            tx_data[i]  = 8'h00;
            tx_valid[i] = 1'b0;
            rx_ready[i] = 1'b1;
            err_clr[i]  = 1'b0;
        end
        waitClk(3);
        reset = 1'b0;
        waitClk(2);
        checkOutput("reset_flags", {miso[0], miso_oe[0], tx_ready[0], rx_valid[0], busy[0], overrun[0], underrun[0]},
                    7'b0010000);
        checkOutput("reset_rx_data", rx_data[0], 8'h00);

        $display("[TB] mode 0, preloaded 0xA5, master sends 0x3C");
        rx_ready[0] = 1'b0;
        txPush(0, 8'hA5, 1'b1);
        csAssert(0);
        checkOutput("oe_selected", miso_oe[0], 1'b1);
        checkOutput("busy_selected", busy[0], 1'b1);
        applyStimulus(0, 8'h3C, 8, mi);
        checkMiso(mi);
        csRelease(0);
        checkOutput("idle_after_cs", {busy[0], miso_oe[0], miso[0]}, 3'b000);
        checkOutput("rx_held_valid", rx_valid[0], 1'b1);
        checkOutput("rx_held_data", rx_data[0], 8'h3C);
        checkOutput("underrun_tail_m0", underrun[0], ERR_EN);
        rxExp.push_back(8'h3C);
        rx_ready[0] = 1'b1;
        waitClk(3);
        checkOutput("rx_cleared", rx_valid[0], 1'b0);

        $display("[TB] mode 3, back-to-back words under one CS");
        txPush(1, 8'hF0, 1'b1);
        csAssert(1);
        txPush(1, 8'h0F, 1'b1);
        rxExp.push_back(8'h11);
        rxExp.push_back(8'h22);
        applyStimulus(1, 8'h11, 8, mi);
        checkMiso(mi);
        applyStimulus(1, 8'h22, 8, mi);
        checkMiso(mi);
        csRelease(1);
        checkOutput("underrun_m3", underrun[1], 1'b0);
        checkOutput("rx_order_done", 32'(rxExp.size()), 32'd0);

        $display("[TB] CS released after 5 bits, then full word");
        errClr(0);
        csAssert(0);
        applyStimulus(0, 8'hFF, 5, mi);
        csRelease(0);
        checkOutput("abort_busy", busy[0], 1'b0);
        checkOutput("abort_no_rx", rx_valid[0], 1'b0);
        txPush(0, 8'h5A, 1'b1);
        rxExp.push_back(8'h81);
        csAssert(0);
        applyStimulus(0, 8'h81, 8, mi);
        checkMiso(mi);
        csRelease(0);

        $display("[TB] two words with consumer stalled");
        rx_ready[0] = 1'b0;
        errClr(0);
        rxExp.push_back(8'hAA);
        csAssert(0);
        applyStimulus(0, 8'hAA, 8, mi);
        applyStimulus(0, 8'h55, 8, mi);
        csRelease(0);
        checkOutput("ovr_keep_data", rx_data[0], 8'hAA);
        checkOutput("ovr_keep_valid", rx_valid[0], 1'b1);
        checkOutput("overrun_set", overrun[0], ERR_EN);
        errClr(0);
        checkOutput("overrun_clr", overrun[0], 1'b0);
        checkOutput("underrun_clr", underrun[0], 1'b0);
        rx_ready[0] = 1'b1;
        waitClk(3);
        checkOutput("ovr_rx_cleared", rx_valid[0], 1'b0);

        $display("[TB] mode 1 LSB first, empty TX buffer");
        misoExp.push_back(8'h00);
        rxExp.push_back(8'h01);
        csAssert(2);
        checkOutput("underrun_empty", underrun[2], ERR_EN);
        applyStimulus(2, 8'h01, 8, mi);
        checkMiso(mi);
        csRelease(2);

        $display("[TB] reset in the middle of a word");
        txPush(0, 8'h77, 1'b0);
        csAssert(0);
        applyStimulus(0, 8'h99, 4, mi);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_flags", {miso[0], miso_oe[0], tx_ready[0], rx_valid[0], busy[0], overrun[0], underrun[0]},
                    7'b0010000);
        checkOutput("midreset_rx_data", rx_data[0], 8'h00);
        waitClk(10);
        checkOutput("midreset_stays_idle", busy[0], 1'b0);
        csRelease(0);
        txPush(0, 8'h12, 1'b1);
        rxExp.push_back(8'h34);
        csAssert(0);
        applyStimulus(0, 8'h34, 8, mi);
        checkMiso(mi);
        csRelease(0);

        waitClk(10);
        checkOutput("rx_all_seen", 32'(rxExp.size()), 32'd0);
        checkOutput("miso_all_seen", 32'(misoExp.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
